// File: rtl/midi_pkg.sv
// Shared MIDI constants, parser state types and status helpers.
// Optional sustain pedal support is enabled with MIDI_PARSER_SUSTAIN_EN.
package midi_pkg;

    typedef logic [6:0] note_t;

    localparam logic [3:0] NOTE_OFF   = 4'h8;
    localparam logic [3:0] NOTE_ON    = 4'h9;
    localparam logic [3:0] CC         = 4'hB;
    localparam logic [3:0] PROG       = 4'hC;
    localparam logic [3:0] CHAN_PRESS = 4'hD;

    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam note_t      CC_SUSTAIN   = 7'd64;
    localparam note_t      DEFAULT_NOTE = 7'd60;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        WAIT_VEL,
        DISCARD
    } parse_state_e;

    typedef enum logic [2:0] {
        RS_NONE,
        RS_NOTE_OFF,
        RS_NOTE_ON,
        RS_CC,
        RS_OTHER
    } run_status_e;

    // Number of data bytes that follow a channel-voice status nibble.
    function automatic logic [1:0] data_len(input logic [3:0] status_hi);
        case (status_hi)
            PROG, CHAN_PRESS:  return 2'd1;
            NOTE_OFF, NOTE_ON,
            CC:                return 2'd2;
            default:           return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/midi_note_stack.sv
// Last-note-priority key stack: entry 0 is the most recent key, entries stay compacted.
// With MIDI_PARSER_SUSTAIN_EN each entry also carries a released flag for the sustain pedal.
module midi_note_stack
    import midi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  op_push,
    input  logic  op_remove,
`ifdef MIDI_PARSER_SUSTAIN_EN
    input  logic  op_release,
    input  logic  op_purge,
`endif
    input  note_t key,
    output note_t nxt_top,
    output logic  nxt_empty
);

    note_t            key_q [DEPTH];
    note_t            key_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] rel_q;
    logic [DEPTH-1:0] rel_d;

    note_t            cmp_key [DEPTH];
    logic [DEPTH-1:0] cmp_vld;
    logic [DEPTH-1:0] cmp_rel;
    logic [DEPTH-1:0] keep;
    int unsigned      pos;

`ifndef MIDI_PARSER_SUSTAIN_EN
    assign rel_q = '0;
`endif

    always_comb begin
        keep = vld_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((op_push || op_remove) && vld_q[i] && key_q[i] == key) begin
                keep[i] = 1'b0;
            end
        end
`ifdef MIDI_PARSER_SUSTAIN_EN
        if (op_purge) begin
            keep = vld_q & ~rel_q;
        end
`endif

        // Surviving entries are packed towards index 0 in their original order.
        pos = 0;
        cmp_vld = '0;
        cmp_rel = '0;
        for (int unsigned j = 0; j < DEPTH; j++) begin
            cmp_key[j] = '0;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (keep[i]) begin
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (j == pos) begin
                        cmp_key[j] = key_q[i];
                        cmp_vld[j] = 1'b1;
                        cmp_rel[j] = rel_q[i];
                    end
                end
                pos++;
            end
        end

        key_d = cmp_key;
        vld_d = cmp_vld;
        rel_d = cmp_rel;
        if (op_push) begin
            key_d[0] = key;
            vld_d[0] = 1'b1;
            rel_d[0] = 1'b0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                key_d[i] = cmp_key[i-1];
                vld_d[i] = cmp_vld[i-1];
                rel_d[i] = cmp_rel[i-1];
            end
        end
`ifdef MIDI_PARSER_SUSTAIN_EN
        if (op_release) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (vld_q[i] && key_q[i] == key) begin
                    rel_d[i] = 1'b1;
                end
            end
        end
`endif
    end

    assign nxt_top   = key_d[0];
    assign nxt_empty = ~vld_d[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                key_q[i] <= '0;
            end
            vld_q <= '0;
        end else begin
            key_q <= key_d;
            vld_q <= vld_d;
        end
    end

`ifdef MIDI_PARSER_SUSTAIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rel_q <= '0;
        end else begin
            rel_q <= rel_d;
        end
    end
`endif

endmodule

// File: rtl/midi_note_parser.sv
// MIDI byte-stream decoder for Note On/Off on one channel, driving note/velocity/gate.
// Define MIDI_PARSER_SUSTAIN_EN to decode the sustain pedal (CC 64).
module midi_note_parser
    import midi_pkg::*;
#(
    parameter logic [3:0]  CHANNEL     = 4'd0,
    parameter bit          OMNI        = 1'b0,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       gate,
    output logic       note_trig,
    output logic       msg_err
);

    parse_state_e state_q, state_d;
    run_status_e  rs_q, rs_d;
    logic         sysex_q, sysex_d;
    logic [1:0]   disc_q, disc_d;
    logic [1:0]   disc_len_q, disc_len_d;
    note_t        key_q, key_d;
    note_t        note_q, note_d;
    note_t        vel_q, vel_d;
    logic         gate_q, gate_d;
    logic         trig_q, trig_d;
    logic         err_q, err_d;

    logic         st_push;
    logic         st_remove;
    note_t        st_nxt_top;
    logic         st_nxt_empty;
    logic         reeval;
`ifdef MIDI_PARSER_SUSTAIN_EN
    logic         st_release;
    logic         st_purge;
    logic         sustain_q, sustain_d;
`endif

    logic [3:0] hi;
    logic       is_rt;
    logic       is_sys;
    logic       is_status;
    logic       accept;

    assign hi        = rx_data[7:4];
    assign is_rt     = rx_data >= REALTIME_MIN;
    assign is_sys    = (hi == 4'hF) && !is_rt;
    assign is_status = rx_data[7] && (hi != 4'hF);
    assign accept    = OMNI || (rx_data[3:0] == CHANNEL);

    always_comb begin
        state_d    = state_q;
        rs_d       = rs_q;
        sysex_d    = sysex_q;
        disc_d     = disc_q;
        disc_len_d = disc_len_q;
        key_d      = key_q;
        err_d      = 1'b0;
        st_push    = 1'b0;
        st_remove  = 1'b0;
`ifdef MIDI_PARSER_SUSTAIN_EN
        st_release = 1'b0;
        st_purge   = 1'b0;
        sustain_d  = sustain_q;
`endif
        if (rx_valid && !is_rt) begin
            if (is_sys) begin
                state_d = IDLE;
                rs_d    = RS_NONE;
                sysex_d = (rx_data == 8'hF0);
            end else if (is_status) begin
                sysex_d    = 1'b0;
                disc_len_d = data_len(hi);
                disc_d     = data_len(hi);
                if (accept && hi == NOTE_ON) begin
                    rs_d    = RS_NOTE_ON;
                    state_d = WAIT_KEY;
                end else if (accept && hi == NOTE_OFF) begin
                    rs_d    = RS_NOTE_OFF;
                    state_d = WAIT_KEY;
`ifdef MIDI_PARSER_SUSTAIN_EN
                end else if (accept && hi == CC) begin
                    rs_d    = RS_CC;
                    state_d = WAIT_KEY;
`endif
                end else begin
                    rs_d    = RS_OTHER;
                    state_d = DISCARD;
                end
            end else if (!sysex_q) begin
                case (state_q)
                    IDLE: begin
                        if (rs_q == RS_NONE) begin
                            err_d = 1'b1;
                        end else if (rs_q == RS_OTHER) begin
                            // Running status on a foreign message: this byte was its first data byte.
                            if (disc_len_q == 2'd2) begin
                                state_d = DISCARD;
                                disc_d  = 2'd1;
                            end
                        end else begin
                            key_d   = rx_data[6:0];
                            state_d = WAIT_VEL;
                        end
                    end
                    WAIT_KEY: begin
                        key_d   = rx_data[6:0];
                        state_d = WAIT_VEL;
                    end
                    WAIT_VEL: begin
                        state_d = IDLE;
                        if (rs_q == RS_NOTE_ON && rx_data[6:0] != '0) begin
                            st_push = 1'b1;
                        end else if (rs_q == RS_NOTE_ON || rs_q == RS_NOTE_OFF) begin
`ifdef MIDI_PARSER_SUSTAIN_EN
                            if (sustain_q) st_release = 1'b1;
                            else
`endif
                            st_remove = 1'b1;
`ifdef MIDI_PARSER_SUSTAIN_EN
                        end else if (rs_q == RS_CC && key_q == CC_SUSTAIN) begin
                            sustain_d = rx_data[6];
                            st_purge  = sustain_q && !rx_data[6];
`endif
                        end
                    end
                    DISCARD: begin
                        if (disc_q <= 2'd1) state_d = IDLE;
                        else                disc_d  = disc_q - 2'd1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    midi_note_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .op_push   (st_push),
        .op_remove (st_remove),
`ifdef MIDI_PARSER_SUSTAIN_EN
        .op_release(st_release),
        .op_purge  (st_purge),
`endif
        .key       (key_q),
        .nxt_top   (st_nxt_top),
        .nxt_empty (st_nxt_empty)
    );

    // Kept separate from the decoder so stack look-ahead never feeds back into op selection.
    always_comb begin
        note_d = note_q;
        vel_d  = vel_q;
        gate_d = gate_q;
        trig_d = 1'b0;
`ifdef MIDI_PARSER_SUSTAIN_EN
        reeval = st_remove || st_purge;
`else
        reeval = st_remove;
`endif
        if (st_push) begin
            note_d = key_q;
            vel_d  = rx_data[6:0];
            gate_d = 1'b1;
            trig_d = 1'b1;
        end else if (reeval) begin
            if (st_nxt_empty) gate_d = 1'b0;
            else              note_d = st_nxt_top;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rs_q       <= RS_NONE;
            sysex_q    <= 1'b0;
            disc_q     <= '0;
            disc_len_q <= 2'd2;
            key_q      <= '0;
            note_q     <= DEFAULT_NOTE;
            vel_q      <= '0;
            gate_q     <= 1'b0;
            trig_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rs_q       <= rs_d;
            sysex_q    <= sysex_d;
            disc_q     <= disc_d;
            disc_len_q <= disc_len_d;
            key_q      <= key_d;
            note_q     <= note_d;
            vel_q      <= vel_d;
            gate_q     <= gate_d;
            trig_q     <= trig_d;
            err_q      <= err_d;
        end
    end

`ifdef MIDI_PARSER_SUSTAIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sustain_q <= 1'b0;
        else     sustain_q <= sustain_d;
    end
`endif

    assign note      = note_q;
    assign velocity  = vel_q;
    assign gate      = gate_q;
    assign note_trig = trig_q;
    assign msg_err   = err_q;

endmodule

// File: tb/tb_midi_note_parser.sv
// Directed bench for midi_note_parser against a queue-based message model.
// Sustain expectations follow MIDI_PARSER_SUSTAIN_EN when the build defines it.
module tb_midi_note_parser;

    localparam int DEPTH = 4;
    localparam int CHAN  = 0;
`ifdef MIDI_PARSER_SUSTAIN_EN
    localparam bit SUS_EN = 1'b1;
`else
    localparam bit SUS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [6:0] note;
    logic [6:0] velocity;
    logic       gate;
    logic       note_trig;
    logic       msg_err;

    int checks = 0;
    int errors = 0;
    int trig_seen = 0;
    int err_seen = 0;

    midi_note_parser #(
        .CHANNEL    (4'(CHAN)),
        .OMNI       (1'b0),
        .STACK_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .note     (note),
        .velocity (velocity),
        .gate     (gate),
        .note_trig(note_trig),
        .msg_err  (msg_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        int key;
        bit rel;
    } ent_t;

    ent_t held[$];
    int   m_note = 60;
    int   m_vel  = 0;
    bit   m_gate = 0;
    bit   m_trig = 0;
    bit   m_err  = 0;
    bit   m_sus  = 0;
    int   cur    = -1;   // -1 none, 0 foreign message, else accepted status nibble
    int   need   = 2;
    bit   sysex  = 0;
    int   dbuf[$];

    function automatic void model_reset();
        held.delete();
        dbuf.delete();
        m_note = 60; m_vel = 0; m_gate = 0; m_trig = 0; m_err = 0; m_sus = 0;
        cur = -1; need = 2; sysex = 0;
    endfunction

    function automatic void drop_key(input int k);
        for (int i = held.size() - 1; i >= 0; i--)
            if (held[i].key == k) held.delete(i);
    endfunction

    function automatic void follow_stack();
        if (held.size() == 0) m_gate = 0;
        else                  m_note = held[0].key;
    endfunction

    function automatic void execute(input int st, input int a, input int v);
        ent_t e;
        if (st == 9 && v > 0) begin
            drop_key(a);
            e.key = a; e.rel = 0;
            held.push_front(e);
            if (held.size() > DEPTH) void'(held.pop_back());
            m_note = a; m_vel = v; m_gate = 1; m_trig = 1;
        end else if (st == 8 || st == 9) begin
            if (m_sus) begin
                for (int i = 0; i < held.size(); i++)
                    if (held[i].key == a) held[i].rel = 1;
            end else begin
                drop_key(a);
                follow_stack();
            end
        end else if (st == 11 && a == 64) begin
            if (m_sus && v < 64) begin
                for (int i = held.size() - 1; i >= 0; i--)
                    if (held[i].rel) held.delete(i);
                follow_stack();
            end
            m_sus = (v >= 64);
        end
    endfunction

    function automatic void model_step(input int b);
        int hi;
        int ch;
        if (b >= 'hF8) return;
        if (b >= 'hF0) begin
            cur = -1; sysex = (b == 'hF0); dbuf.delete();
            return;
        end
        if (b >= 'h80) begin
            hi = b / 16; ch = b % 16;
            sysex = 0; dbuf.delete();
            need = (hi == 12 || hi == 13) ? 1 : 2;
            if (ch == CHAN && (hi == 8 || hi == 9 || (SUS_EN && hi == 11))) cur = hi;
            else cur = 0;
            return;
        end
        if (sysex) return;
        if (cur < 0) begin
            m_err = 1;
            return;
        end
        dbuf.push_back(b);
        if (dbuf.size() == need) begin
            if (cur != 0) execute(cur, dbuf[0], dbuf[1]);
            dbuf.delete();
        end
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        m_trig = 0;
        m_err  = 0;
        if (rst)           model_reset();
        else if (rx_valid) model_step(int'(rx_data));
    end

    // ---------------- per-cycle comparison ----------------
    initial forever begin
        @(negedge clk);
        if (note_trig === 1'b1) trig_seen++;
        if (msg_err === 1'b1)   err_seen++;
        if (!rst) begin
            checks++;
            if (note !== 7'(m_note) || velocity !== 7'(m_vel) || gate !== m_gate ||
                note_trig !== m_trig || msg_err !== m_err) begin
                errors++;
                $display("FAIL cycle t=%0t actual/required note=%0d/%0d vel=%0d/%0d gate=%0b/%0b trig=%0b/%0b err=%0b/%0b",
                         $time, note, m_note, velocity, m_vel, gate, m_gate, note_trig, m_trig, msg_err, m_err);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send(a); send(b); send(c);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_note", int'(note), 60);
        check("rst_vel", int'(velocity), 0);
        check("rst_gate", int'(gate), 0);
        check("rst_trig", int'(note_trig), 0);
        check("rst_err", int'(msg_err), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    int t0;
    int e0;

    initial begin
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single Note On
        t0 = trig_seen;
        send3(8'h90, 8'h3C, 8'h64);
        settle();
        check("s1_note", int'(note), 60);
        check("s1_vel", int'(velocity), 100);
        check("s1_gate", int'(gate), 1);
        check("s1_trig_cnt", trig_seen - t0, 1);
        send3(8'h80, 8'h3C, 8'h00);
        settle();
        check("s1_off_gate", int'(gate), 0);

        // Running status and legato return
        t0 = trig_seen;
        send3(8'h90, 8'h3C, 8'h64);
        send(8'h40); send(8'h50);
        settle();
        check("s2_note_hi", int'(note), 64);
        check("s2_vel_hi", int'(velocity), 80);
        send3(8'h80, 8'h40, 8'h00);
        settle();
        check("s2_legato_note", int'(note), 60);
        check("s2_legato_vel", int'(velocity), 80);
        check("s2_legato_gate", int'(gate), 1);
        check("s2_trig_cnt", trig_seen - t0, 2);
        send3(8'h80, 8'h3C, 8'h00);
        settle();
        check("s2_rel_gate", int'(gate), 0);
        check("s2_rel_note", int'(note), 60);

        // Real-time byte inside a message, then Note On velocity 0 as release
        send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
        settle();
        check("s3_note", int'(note), 60);
        check("s3_vel", int'(velocity), 100);
        check("s3_gate", int'(gate), 1);
        t0 = trig_seen;
        send(8'h3C); send(8'h70);
        settle();
        check("retrig_cnt", trig_seen - t0, 1);
        check("retrig_vel", int'(velocity), 112);
        send(8'h3C); send(8'h00);
        settle();
        check("s3_vel0_gate", int'(gate), 0);

        // No running status, foreign channel, foreign messages, SysEx
        do_reset();
        e0 = err_seen;
        send(8'h45);
        settle();
        check("s4_err_cnt", err_seen - e0, 1);
        check("s4_note_hold", int'(note), 60);
        send3(8'h91, 8'h3C, 8'h64);
        send(8'hC0); send(8'h05); send(8'h3C);
        send3(8'hA0, 8'h3C, 8'h10);
        settle();
        check("s4_ch1_gate", int'(gate), 0);
        check("s4_err_cnt2", err_seen - e0, 1);
        send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C);
        settle();
        check("s4_sysex_err", err_seen - e0, 2);

        // Stack overflow drops the oldest key
        send3(8'h90, 8'h3C, 8'h64);
        send(8'h3E); send(8'h64);
        send(8'h40); send(8'h64);
        send(8'h41); send(8'h64);
        send(8'h43); send(8'h64);
        send3(8'h80, 8'h43, 8'h00);
        settle();
        check("s5_top_after_rel", int'(note), 65);
        send(8'h41); send(8'h00);
        send(8'h40); send(8'h00);
        send(8'h3E); send(8'h00);
        settle();
        check("s5_gate", int'(gate), 0);
        check("s5_note_hold", int'(note), 62);

        // Reset in the middle of a message
        send(8'h90); send(8'h3C);
        do_reset();
        e0 = err_seen;
        send(8'h64);
        settle();
        check("s5_post_rst_err", err_seen - e0, 1);

        // Sustain pedal
        send3(8'hB0, 8'h40, 8'h7F);
        send3(8'h90, 8'h3C, 8'h64);
        send3(8'h80, 8'h3C, 8'h00);
        settle();
        check("s6_sus_gate", int'(gate), SUS_EN ? 1 : 0);
        send3(8'hB0, 8'h40, 8'h00);
        settle();
        check("s6_pedal_up_gate", int'(gate), 0);
        check("s6_note", int'(note), 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
